// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads to
// instruction memory and presents each fetched word with its PC through a valid/ready register.
module instr_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       PC_INC   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    BOOT  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    HOLD  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] inflight_pc;
  logic [DATA_W-1:0] skid;
  logic [ADDR_W-1:0] skid_pc;

  logic              consume_c;
  logic [ADDR_W-1:0] redirect_tgt_c;
  logic [ADDR_W-1:0] pc_next_c;

  assign consume_c      = instr_valid & instr_ready;
  assign redirect_tgt_c = redirect_pc & ~ADDR_W'(3);
  assign pc_next_c      = pc + ADDR_W'(PC_INC);

  // The address bus is the PC register itself; it only moves on gnt or redirect.
  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      inflight_pc <= '0;
      skid        <= '0;
      skid_pc     <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect overrides everything; an already accepted request must still be drained.
      pc          <= redirect_tgt_c;
      instr_valid <= 1'b0;
      skid        <= '0;
      skid_pc     <= '0;
      case (state)
        REQ: begin
          if (imem_gnt) begin
            state    <= DRAIN;
            imem_req <= 1'b0;
          end else begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        WAIT, DRAIN: begin
          if (imem_rvalid) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end else begin
            state    <= DRAIN;
            imem_req <= 1'b0;
          end
        end
        default: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
      endcase
    end else begin
      if (consume_c) begin
        instr_valid <= 1'b0;
      end
      case (state)
        BOOT: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_gnt) begin
            pc          <= pc_next_c;
            inflight_pc <= pc;
            state       <= WAIT;
            imem_req    <= 1'b0;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (!instr_valid || consume_c) begin
              instr       <= imem_rdata;
              instr_pc    <= inflight_pc;
              instr_valid <= 1'b1;
              state       <= REQ;
              imem_req    <= 1'b1;
            end else begin
              skid    <= imem_rdata;
              skid_pc <= inflight_pc;
              state   <= HOLD;
            end
          end
        end
        HOLD: begin
          if (consume_c) begin
            instr       <= skid;
            instr_pc    <= skid_pc;
            instr_valid <= 1'b1;
            state       <= REQ;
            imem_req    <= 1'b1;
          end
        end
        DRAIN: begin
          if (imem_rvalid) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        default: begin
          state    <= BOOT;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: instruction memory model with configurable
// latency and grant withholding, plus an output scoreboard of expected (instr, pc) pairs.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  instr_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  int          out_cyc[$];

  int          lat_cfg = 1;
  int          withhold_cfg = 0;
  int          withhold;
  int          cnt;
  logic        pending;
  logic [31:0] pend_addr;
  logic [31:0] gnt_addr;
  logic [31:0] last_gnt_addr;
  int          gnt_count;
  int          ng_cycles;
  int          cyc;

  logic        prev_stall;
  logic        prev_req_ng;
  logic [31:0] prev_instr;
  logic [31:0] prev_pc;
  logic [31:0] prev_addr;
  logic [63:0] expv;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h08A0_1900;
      32'h0000_0004: return 32'h08A1_1901;
      32'h0000_0008: return 32'h0401_42B2;
      default:       return a ^ 32'h5A5A_0000;
    endcase
  endfunction

  function automatic logic [63:0] exp_of(input logic [31:0] pc);
    return {mem_word(pc), pc};
  endfunction

  // Memory model: decides gnt/rvalid 1 time unit after each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imem_gnt      = 1'b0;
      imem_rvalid   = 1'b0;
      imem_rdata    = 32'h0;
      pending       = 1'b0;
      cnt           = 0;
      gnt_count     = 0;
      last_gnt_addr = 32'hFFFF_FFFF;
      withhold      = withhold_cfg;
    end else begin
      #1;
      if (imem_gnt) begin
        pending       = 1'b1;
        pend_addr     = gnt_addr;
        cnt           = lat_cfg;
        gnt_count++;
        last_gnt_addr = gnt_addr;
      end
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'hDEAD_BEEF;
      if (pending) begin
        if (cnt > 1) cnt--;
        else begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
          pending     = 1'b0;
        end
      end
      if (imem_req && !pending) begin
        if (withhold > 0) withhold--;
        else begin
          imem_gnt = 1'b1;
          gnt_addr = imem_addr;
        end
      end
    end
  end

  // Output scoreboard and protocol monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall  = 1'b0;
      prev_req_ng = 1'b0;
      ng_cycles   = 0;
      cyc         = 0;
      out_cyc.delete();
    end else begin
      cyc++;
      if (prev_stall) begin
        check("hold_instr", 64'(instr), 64'(prev_instr));
        check("hold_pc", 64'(instr_pc), 64'(prev_pc));
        check("hold_valid", 64'(instr_valid), 64'(1));
      end
      if (prev_req_ng) begin
        check("req_hold", 64'(imem_req), 64'(1));
        check("addr_hold", 64'(imem_addr), 64'(prev_addr));
      end
      if (imem_req) check("one_outstanding", 64'(pending), 64'(0));
      if (instr_valid && instr_ready) begin
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : {32'hDEAD_DEAD, 32'hDEAD_DEAD};
        check("out_instr", 64'(instr), 64'(expv[63:32]));
        check("out_pc", 64'(instr_pc), 64'(expv[31:0]));
        out_cyc.push_back(cyc);
      end
      if (imem_req && !imem_gnt) ng_cycles++;
      prev_stall  = instr_valid && !instr_ready && !redirect_valid;
      prev_req_ng = imem_req && !imem_gnt && !redirect_valid;
      prev_instr  = instr;
      prev_pc     = instr_pc;
      prev_addr   = imem_addr;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int l, input int wh, input logic rdy);
    lat_cfg        = l;
    withhold_cfg   = wh;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = rdy;
    exp_q.delete();
    repeat (3) step();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) step();
    instr_ready = 1'b0;
    check(tag, 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int d1, d2;
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    instr_ready    = 1'b0;

    // Boot: reset values, first request timing, in-order delivery 2 cycles apart.
    do_reset(1, 0, 1'b1);
    check("rst_valid", 64'(instr_valid), 64'(0));
    check("rst_instr", 64'(instr), 64'(0));
    check("rst_instr_pc", 64'(instr_pc), 64'(0));
    check("rst_req", 64'(imem_req), 64'(0));
    check("rst_addr", 64'(imem_addr), 64'(0));
    exp_q.push_back(exp_of(32'h0));
    exp_q.push_back(exp_of(32'h4));
    exp_q.push_back(exp_of(32'h8));
    rst_n = 1'b1;
    @(negedge clk);
    check("boot_c1_req", 64'(imem_req), 64'(0));
    @(negedge clk);
    check("boot_c2_req", 64'(imem_req), 64'(1));
    check("boot_c2_addr", 64'(imem_addr), 64'(0));
    drain("boot_drain");
    d1 = (out_cyc.size() >= 3) ? out_cyc[1] - out_cyc[0] : -1;
    d2 = (out_cyc.size() >= 3) ? out_cyc[2] - out_cyc[1] : -1;
    check("boot_gap1", 64'(d1), 64'(2));
    check("boot_gap2", 64'(d2), 64'(2));

    // Stall: output holds pc 0, pc 4 parks in the skid buffer, no further requests.
    do_reset(1, 0, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_of(32'(i * 4)));
    rst_n = 1'b1;
    repeat (10) step();
    check("stall_instr", 64'(instr), 64'(32'h08A0_1900));
    check("stall_pc", 64'(instr_pc), 64'(0));
    check("stall_valid", 64'(instr_valid), 64'(1));
    check("stall_req", 64'(imem_req), 64'(0));
    check("stall_gnts", 64'(gnt_count), 64'(2));
    instr_ready = 1'b1;
    drain("stall_drain");

    // Redirect while waiting on pc 8 with latency 3: that response is discarded.
    do_reset(3, 0, 1'b1);
    exp_q.push_back(exp_of(32'h0));
    exp_q.push_back(exp_of(32'h4));
    exp_q.push_back(exp_of(32'h40));
    exp_q.push_back(exp_of(32'h44));
    rst_n = 1'b1;
    for (int i = 0; i < 100 && gnt_count < 3; i++) step();
    check("rd_gnt8", 64'(last_gnt_addr), 64'(32'h8));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0042;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 100 && gnt_count < 4; i++) step();
    check("rd_next_addr", 64'(last_gnt_addr), 64'(32'h40));
    drain("rd_drain");

    // Wrap: redirect from BOOT to the top of the address space.
    do_reset(1, 0, 1'b1);
    exp_q.push_back(exp_of(32'hFFFF_FFF8));
    exp_q.push_back(exp_of(32'hFFFF_FFFC));
    exp_q.push_back(exp_of(32'h0000_0000));
    exp_q.push_back(exp_of(32'h0000_0004));
    rst_n          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF9;
    step();
    redirect_valid = 1'b0;
    drain("wrap_drain");

    // Grant withheld for 4 cycles: address held, a single request accepted.
    do_reset(1, 4, 1'b1);
    exp_q.push_back(exp_of(32'h0));
    exp_q.push_back(exp_of(32'h4));
    rst_n = 1'b1;
    for (int i = 0; i < 100 && gnt_count < 1; i++) step();
    check("wh_gnt_addr", 64'(last_gnt_addr), 64'(0));
    check("wh_gnt_count", 64'(gnt_count), 64'(1));
    check("wh_ng_cycles", 64'(ng_cycles), 64'(4));
    drain("wh_drain");

    // Asynchronous reset mid-WAIT, then a clean restart at the reset PC.
    do_reset(3, 0, 1'b1);
    exp_q.push_back(exp_of(32'h0));
    rst_n = 1'b1;
    for (int i = 0; i < 100 && gnt_count < 2; i++) step();
    check("ar_pre_instr", 64'(instr), 64'(32'h08A0_1900));
    check("ar_pre_q", 64'(exp_q.size()), 64'(0));
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(instr_valid), 64'(0));
    check("ar_instr", 64'(instr), 64'(0));
    check("ar_req", 64'(imem_req), 64'(0));
    check("ar_addr", 64'(imem_addr), 64'(0));
    repeat (2) step();
    exp_q.delete();
    exp_q.push_back(exp_of(32'h0));
    exp_q.push_back(exp_of(32'h4));
    instr_ready = 1'b1;
    rst_n = 1'b1;
    drain("ar_drain");

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
